// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared default sizes for the memory arbiter and its neighbours
package mem_arbiter_pkg;

  localparam int DefaultMemAndIOAddrSize = 16;
  localparam int DefaultWordSize         = 16;
  localparam int DefaultMaxBurst         = 8;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of the shared MemAndIO ram
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MemAddrSize = DefaultMemAndIOAddrSize,
  parameter int WordSize    = DefaultWordSize,
  parameter int MaxBurst    = DefaultMaxBurst
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [MemAddrSize-1:0] addr0,
  input  logic [MemAddrSize-1:0] addr1,
  input  logic [WordSize-1:0]    wdata0,
  input  logic [WordSize-1:0]    wdata1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic [WordSize-1:0]    rdata0,
  output logic [WordSize-1:0]    rdata1,
  output logic [MemAddrSize-1:0] mem_addr,
  output logic                   mem_we,
  output logic [WordSize-1:0]    mem_wdata,
  input  logic [WordSize-1:0]    mem_rdata
);

  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxBurst);
  localparam logic [CntW-1:0] CntLast = CntW'(MaxBurst - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic            xfer0, xfer1, burst_done;

  assign xfer0      = gnt0_q & req0;
  assign xfer1      = gnt1_q & req1;
  // The transfer happening now is the MaxBurst-th (or later, once saturated).
  assign burst_done = (cnt_q >= CntLast);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                  state_d = req1 ? OWN1 : IDLE;
        else if (burst_done && req1) state_d = OWN1;
        if (state_d != OWN0) last_d = 1'b0;
      end
      OWN1: begin
        if (!req1)                  state_d = req0 ? OWN0 : IDLE;
        else if (burst_done && req0) state_d = OWN0;
        if (state_d != OWN1) last_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)                  cnt_d = '0;
    else if ((xfer0 || xfer1) && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    else                                     cnt_d = cnt_q;

    gnt0_d    = (state_d == OWN0);
    gnt1_d    = (state_d == OWN1);
    // Read-valid follows the port that issued the read, even across a handover.
    rvalid0_d = xfer0 & ~we0;
    rvalid1_d = xfer1 & ~we1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    mem_addr  = addr0;
    mem_wdata = wdata0;
    mem_we    = 1'b0;
    if (xfer1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end else if (xfer0) begin
      mem_we = we0;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MemAddrSize, default `DefaultMemAndIOAddrSize, which sets the memory address width.
REQ-002 SHALL have parameter WordSize, default `DefaultWordSize, which sets the data width.
REQ-003 SHALL have parameter MaxBurst, default `DefaultMaxBurst (8), which sets the maximum number of transfers per grant while the other port waits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req0 / req1, input, 1 bit: port 0 (CPU) / port 1 (DMA) requests access.
REQ-007 SHALL have ports we0 / we1, input, 1 bit: write enable qualifying the request.
REQ-008 SHALL have ports addr0 / addr1, input, MemAddrSize bits: requester address.
REQ-009 SHALL have ports wdata0 / wdata1, input, WordSize bits: requester write data.
REQ-010 SHALL have ports gnt0 / gnt1, output, 1 bit: registered grant.
REQ-011 SHALL have ports rvalid0 / rvalid1, output, 1 bit: registered read-data-valid flag.
REQ-012 SHALL have ports rdata0 / rdata1, output, WordSize bits: read data, equal to mem_rdata.
REQ-013 SHALL have port mem_addr, output, MemAddrSize bits: address to the shared MemAndIO ram.
REQ-014 SHALL have port mem_we, output, 1 bit: write enable to the ram.
REQ-015 SHALL have port mem_wdata, output, WordSize bits: write data to the ram.
REQ-016 SHALL have port mem_rdata, input, WordSize bits: ram read data, valid one cycle after its address.

Function
REQ-017 SHALL implement FSM states IDLE, OWN0 and OWN1; gnt0 is 1 only in OWN0, and gnt1 is 1 only in OWN1.
REQ-018 SHALL define a transfer as any cycle with gntN=1 and reqN=1; mem_addr, mem_we and mem_wdata are combinationally muxed from the owner.
REQ-019 SHALL force mem_we=0 whenever no transfer is occurring; mem_addr and mem_wdata then hold the port-0 values.
REQ-020 SHALL grant from IDLE with a latency of one cycle: a request seen in cycle t gives gnt in cycle t+1.
REQ-021 SHALL resolve requests in IDLE as follows: with one request, grant it; with both, grant the port not served last (round-robin pointer).
REQ-022 SHALL count transfers in the OWNx state with a burst counter, which clears on every state change.
REQ-023 SHALL leave OWNx when reqx=0: go to OWNy if reqy=1, else go to IDLE.
REQ-024 SHALL force a switch to OWNy after the MaxBurst-th transfer if reqy=1; if reqy=0, ownership continues and the counter saturates.
REQ-025 SHALL switch ownership without an idle bubble; simultaneous owner-drop and other-raise goes directly to the other port.
REQ-026 SHALL assert rvalidN for exactly one cycle, on the cycle after each read transfer on port N.
REQ-027 SHALL deliver the rdata of a read issued on the last transfer before a switch via rvalid of the originating port, not the new owner.
REQ-028 SHALL update the round-robin pointer to the owner on every exit from OWNx.

Reset
REQ-029 SHALL, while reset=0, immediately force state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_we=0, burst counter 0, and pointer favouring port 0.
REQ-030 SHALL abort any burst on reset mid-burst, with no rvalid for an in-flight read; the first grant after release follows REQ-020.

Structure
REQ-031 SHALL place `DefaultMaxBurst in the shared const.h alongside the existing default sizes; FSM state encodings remain local to the module.
REQ-032 SHALL be a single module with no sub-module; it is instantiated between cpu, a DMA master and the MemAndIO ram in computer.

Verification (MaxBurst=4)
REQ-033 SHALL be tested with: req0 only, reads at 0x10..0x12 -> gnt0 at t+1, rvalid0 on three consecutive cycles with ram contents, gnt1=0.
REQ-034 SHALL be tested with: req0 and req1 together from reset -> OWN0 first; after 4 transfers, OWN1 next cycle with no IDLE gap.
REQ-035 SHALL be tested with: both continuously requesting for 24 cycles -> ownership alternates in 4-transfer bursts, and no port waits more than 4 transfers.
REQ-036 SHALL be tested with: port1 writes 0xA5 to address 0x20 and then port0 reads 0x20 -> rdata0=0xA5 with rvalid0; mem_we never 1 while neither port is granted.
REQ-037 SHALL be tested with: reset low mid-burst during a read -> gnt and rvalid drop to 0 at once, state IDLE; after release, req1 is granted in one cycle.
